// File: rtl/d_tty_pkg.sv
// rtl/d_tty_pkg.sv - register map, field indices and TX state encoding for d_tty_uart
package d_tty_pkg;

    localparam logic [1:0] ADDR_TXDATA = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_LEVEL_LSB = 8;
    localparam int ST_LEVEL_W   = 8;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_DIV_LSB = 16;
    localparam int CTRL_DIV_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead head, push accepted on full when popping
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push & ~do_pop)
                level <= level + 1'b1;
            else if (do_pop & ~do_push)
                level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/d_tty_uart.sv
// rtl/d_tty_uart.sv - memory-mapped TTY with TX FIFO, parallel strobe or serial UART output
module d_tty_uart import d_tty_pkg::*; #(
    parameter int          DATA_W        = 7,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] CLK_DIV_RESET = 16'd15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        addr_i,
    input  logic              we_i,
    input  logic              be0_i,
    input  logic              be1_i,
    input  logic              be2_i,
    input  logic              be3_i,
    input  logic [31:0]       din_i,
    output logic [31:0]       dout_o,
    output logic [DATA_W-1:0] tty_o,
    output logic              tty_we_o,
    output logic              txd_o,
    output logic              irq_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              ctrl_en;
    logic              ctrl_mode;
    logic              ctrl_irq_en;
    logic [15:0]       ctrl_div;
    logic              overflow;

    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic [DATA_W-1:0] fifo_head;

    tx_state_t         state;
    tx_state_t         state_nxt;
    logic              txd_nxt;
    logic [15:0]       div_l;
    logic [15:0]       cyc_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;

    logic              wr_txdata;
    logic              wr_status;
    logic              wr_ctrl;
    logic              pop;
    logic              busy;
    logic              bit_done;
    logic              unused_bits;

    assign wr_txdata = we_i & be0_i & (addr_i == ADDR_TXDATA);
    assign wr_status = we_i & be0_i & (addr_i == ADDR_STATUS);
    assign wr_ctrl   = we_i & (addr_i == ADDR_CTRL);
    assign pop       = ctrl_en & ~fifo_empty & (state == IDLE);
    assign busy      = (state != IDLE);
    assign bit_done  = (cyc_cnt == div_l);
    assign irq_o     = ctrl_irq_en & fifo_empty & ~busy;
    assign unused_bits = &{1'b0, be1_i, din_i};

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (din_i[DATA_W-1:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (fifo_head)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en     <= 1'b1;
            ctrl_mode   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_div    <= CLK_DIV_RESET;
            overflow    <= 1'b0;
        end else begin
            if (wr_ctrl & be0_i) begin
                ctrl_en     <= din_i[CTRL_EN];
                ctrl_mode   <= din_i[CTRL_MODE];
                ctrl_irq_en <= din_i[CTRL_IRQ_EN];
            end
            if (wr_ctrl & be2_i) ctrl_div[7:0]  <= din_i[CTRL_DIV_LSB +: 8];
            if (wr_ctrl & be3_i) ctrl_div[15:8] <= din_i[CTRL_DIV_LSB + 8 +: 8];
            if (wr_txdata & fifo_full & ~pop)
                overflow <= 1'b1;
            else if (wr_status & din_i[ST_OVF])
                overflow <= 1'b0;
        end
    end

    // Parallel mode never leaves IDLE, so a strobe can issue every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tty_o    <= '0;
            tty_we_o <= 1'b0;
        end else begin
            tty_we_o <= pop & ~ctrl_mode;
            if (pop & ~ctrl_mode) tty_o <= fifo_head;
        end
    end

    always_comb begin
        state_nxt = state;
        txd_nxt   = txd_o;
        case (state)
            IDLE: begin
                if (pop && ctrl_mode) begin
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt = DATA;
                    txd_nxt   = shreg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        txd_nxt   = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    // div and the character are captured at frame start so CTRL writes cannot disturb a frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            txd_o   <= 1'b1;
            div_l   <= '0;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            state <= state_nxt;
            txd_o <= txd_nxt;
            if (state == IDLE) begin
                cyc_cnt <= '0;
                bit_idx <= '0;
                if (pop && ctrl_mode) begin
                    div_l <= ctrl_div;
                    shreg <= fifo_head;
                end
            end else if (bit_done) begin
                cyc_cnt <= '0;
                if (state == DATA) begin
                    bit_idx <= bit_idx + 1'b1;
                    shreg   <= shreg >> 1;
                end
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        dout_o = '0;
        case (addr_i)
            ADDR_STATUS: begin
                dout_o[ST_EMPTY] = fifo_empty;
                dout_o[ST_FULL]  = fifo_full;
                dout_o[ST_BUSY]  = busy;
                dout_o[ST_OVF]   = overflow;
                dout_o[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
            end
            ADDR_CTRL: begin
                dout_o[CTRL_EN]     = ctrl_en;
                dout_o[CTRL_MODE]   = ctrl_mode;
                dout_o[CTRL_IRQ_EN] = ctrl_irq_en;
                dout_o[CTRL_DIV_LSB +: CTRL_DIV_W] = ctrl_div;
            end
            default: dout_o = '0;
        endcase
    end

endmodule
